// File: rtl/wfg_drive_spi_arb_pkg.sv
// Shared types and constants for the SPI driver round-robin arbiter.
package wfg_drive_spi_arb_pkg;

    localparam int unsigned MAX_NUM_CH = 8;
    localparam int unsigned MAX_IDX_W  = 3;
    localparam int unsigned BEAT_CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Index of the set bit in a one-hot vector; zero when the vector is empty.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_NUM_CH-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_NUM_CH; i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wfg_drive_spi_arb_if.sv
// Stream bus between the stimulus requesters, the arbiter and the SPI driver.
interface wfg_drive_spi_arb_if #(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned AXIS_DATA_WIDTH = 32
);
    logic [NUM_CH-1:0]                 s_axis_tvalid_i;
    logic [NUM_CH-1:0]                 s_axis_tlast_i;
    logic [NUM_CH*AXIS_DATA_WIDTH-1:0] s_axis_tdata_i;
    logic [NUM_CH-1:0]                 s_axis_tready_o;
    logic                              m_axis_tvalid_o;
    logic                              m_axis_tready_i;
    logic                              m_axis_tlast_o;
    logic [AXIS_DATA_WIDTH-1:0]        m_axis_tdata_o;
    logic [NUM_CH-1:0]                 ch_sel_o;

    modport slave (
        input  s_axis_tvalid_i, s_axis_tlast_i, s_axis_tdata_i, m_axis_tready_i,
        output s_axis_tready_o, m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o, ch_sel_o
    );

    modport master (
        output s_axis_tvalid_i, s_axis_tlast_i, s_axis_tdata_i, m_axis_tready_i,
        input  s_axis_tready_o, m_axis_tvalid_o, m_axis_tlast_o, m_axis_tdata_o, ch_sel_o
    );
endinterface

// File: rtl/wfg_rr_picker.sv
// Combinational round-robin picker: first request after last_grant, with wrap.
module wfg_rr_picker #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_last_grant,
    output logic [NUM_CH-1:0] o_grant,
    output logic              o_any
);

    always_comb begin
        logic [IDX_W:0] v_idx;
        v_idx   = '0;
        o_grant = '0;
        o_any   = 1'b0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            v_idx = (IDX_W+1)'(i_last_grant) + (IDX_W+1)'(i);
            if (v_idx >= (IDX_W+1)'(NUM_CH)) v_idx = v_idx - (IDX_W+1)'(NUM_CH);
            if (!o_any && i_req[v_idx[IDX_W-1:0]]) begin
                o_grant[v_idx[IDX_W-1:0]] = 1'b1;
                o_any                     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wfg_drive_spi_arb.sv
// Round-robin scheduler sharing one SPI driver between NUM_CH stream requesters.
// Optional packet lock (grant held until tlast) with WFG_DRIVE_SPI_ARB_LOCK_EN.
module wfg_drive_spi_arb
    import wfg_drive_spi_arb_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned AXIS_DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_en_q_i,
    input  logic [NUM_CH-1:0]     cfg_mask_q_i,
    input  logic                  cnt_clr_i,
    wfg_drive_spi_arb_if.slave    bus,
    output logic [BEAT_CNT_W-1:0] beat_cnt_o
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);
    localparam int unsigned W     = AXIS_DATA_WIDTH;
    localparam logic [BEAT_CNT_W-1:0] CNT_MAX = '1;

    state_e                r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_last_grant;
    logic [IDX_W-1:0]      w_win_idx;
    logic [NUM_CH-1:0]     w_eligible, w_req, w_grant, w_tready;
    logic                  w_any, w_accept, w_deliver;
    logic [W-1:0]          w_win_data, r_tdata;
    logic                  w_win_last, r_tlast;
    logic [NUM_CH-1:0]     r_ch_sel;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;

    assign w_eligible = bus.s_axis_tvalid_i & cfg_mask_q_i;

`ifdef WFG_DRIVE_SPI_ARB_LOCK_EN
    logic             r_lock;
    logic [IDX_W-1:0] r_lock_ch;
    logic             w_lock_act;

    // A lock only holds while its channel stays enabled in the mask.
    assign w_lock_act = r_lock & cfg_mask_q_i[r_lock_ch];
    assign w_req      = w_lock_act ? (w_eligible & (NUM_CH'(1) << r_lock_ch)) : w_eligible;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
        end else if (w_accept) begin
            r_lock    <= ~w_win_last;
            r_lock_ch <= w_win_idx;
        end else if (r_lock && !cfg_mask_q_i[r_lock_ch]) begin
            r_lock    <= 1'b0;
        end
    end
`else
    assign w_req = w_eligible;
`endif

    wfg_rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any        (w_any)
    );

    assign w_win_idx = IDX_W'(onehot_to_idx(MAX_NUM_CH'(w_grant)));

    // Select the winning channel's beat.
    always_comb begin
        w_win_data = '0;
        w_win_last = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_grant[c]) begin
                w_win_data = bus.s_axis_tdata_i[c*W +: W];
                w_win_last = bus.s_axis_tlast_i[c];
            end
        end
    end

    // Next state and handshake decode; ready never depends on the driver side.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_deliver   = 1'b0;
        w_tready    = '0;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_en_q_i && w_any) begin
                    w_accept    = 1'b1;
                    w_tready    = w_grant;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.m_axis_tready_i) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Output buffer and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tdata      <= '0;
            r_tlast      <= 1'b0;
            r_ch_sel     <= '0;
            r_last_grant <= IDX_W'(NUM_CH - 1);
        end else if (w_accept) begin
            r_tdata      <= w_win_data;
            r_tlast      <= w_win_last;
            r_ch_sel     <= w_grant;
            r_last_grant <= w_win_idx;
        end
    end

    // Delivered-frame counter; clear wins over a simultaneous delivery.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr_i)                   r_beat_cnt <= '0;
        else if (w_deliver && r_beat_cnt != CNT_MAX) r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
    end

    assign bus.s_axis_tready_o = w_tready;
    assign bus.m_axis_tvalid_o = (r_state == ST_HOLD);
    assign bus.m_axis_tlast_o  = r_tlast;
    assign bus.m_axis_tdata_o  = r_tdata;
    assign bus.ch_sel_o        = r_ch_sel;
    assign beat_cnt_o          = r_beat_cnt;

endmodule

// File: doc/wfg_drive_spi_arb.md
# wfg_drive_spi_arb

Round-robin scheduler that shares one `wfg_drive_spi` instance between up to NUM_CH AXI-stream requesters (stimulus cores). It picks one enabled, valid channel per SPI frame and buffers that channel's word in a one-entry output register. It then presents the word on the driver's AXI-stream input and a one-hot channel select, so downstream logic can steer chip select. It sits between the core/pattern stimulus outputs and the SPI driver.

## Interface
- NUM_CH, 4: number of requester channels, 2..8.
- AXIS_DATA_WIDTH, 32: stream data width.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- ctrl_en_q_i  in  1  arbiter enable.
- cfg_mask_q_i  in  NUM_CH  per-channel enable mask.
- cnt_clr_i  in  1  clears beat counter.
- s_axis_tvalid_i  in  NUM_CH  per-channel valid.
- s_axis_tlast_i  in  NUM_CH  per-channel last.
- s_axis_tdata_i  in  NUM_CH*AXIS_DATA_WIDTH  per-channel data, channel c at [c*W +: W].
- s_axis_tready_o  out  NUM_CH  per-channel ready, at most one bit high.
- m_axis_tvalid_o  out  1  to SPI driver.
- m_axis_tready_i  in  1  from SPI driver. A one-cycle pulse when a frame is loaded.
- m_axis_tlast_o  out  1  buffered tlast.
- m_axis_tdata_o  out  AXIS_DATA_WIDTH  buffered data.
- ch_sel_o  out  NUM_CH  one-hot owner of the buffered word.
- beat_cnt_o  out  16  frames delivered, saturating.

## Operation
- States:
  - ST_IDLE: no buffered word.
  - ST_HOLD: word buffered, m_axis_tvalid_o=1.
- Eligible channel: s_axis_tvalid_i[c] & cfg_mask_q_i[c].
- ST_IDLE with ctrl_en_q_i=1 and at least one eligible channel:
  - Winner = first eligible channel searching from (last_grant+1) mod NUM_CH upward with wrap.
  - s_axis_tready_o[winner]=1 combinationally in that cycle; the beat is accepted.
  - Next edge: tdata/tlast latched, ch_sel_o=onehot(winner), last_grant=winner, go to ST_HOLD.
- ST_IDLE otherwise: all s_axis_tready_o=0, stay.
- ST_HOLD:
  - All s_axis_tready_o=0.
  - On m_axis_tready_i=1: next edge clears m_axis_tvalid_o, increments beat_cnt_o (saturates at 0xFFFF), returns to ST_IDLE.
  - ch_sel_o and tdata keep their last values.
- ctrl_en_q_i falling in ST_HOLD: the buffered word is still delivered, never dropped. No new accept until re-enabled.
- cfg_mask_q_i changes affect only the next arbitration. A buffered word is delivered regardless of mask.
- cnt_clr_i has priority over increment when both occur in the same cycle: counter becomes 0.
- rst in any state: discards the buffer and returns to ST_IDLE. The source beat is not re-requested.

## Timing
- Reset values:
  - s_axis_tready_o=0, m_axis_tvalid_o=0, m_axis_tlast_o=0, m_axis_tdata_o=0, ch_sel_o=0, beat_cnt_o=0.
  - last_grant=NUM_CH-1, so channel 0 wins first.
- Latency: accept in cycle N, m_axis_tvalid_o high from cycle N+1.
- Release: m_axis_tready_i in cycle M, m_axis_tvalid_o low at M+1, next accept possible in M+1.
- Maximum throughput: one beat per 2 cycles.
- s_axis_tready_o is a function of state, mask, valids and last_grant only. It has no dependency on m_axis_tready_i, so there is no combinational path through the block.

## Configuration
- WFG_DRIVE_SPI_ARB_LOCK_EN
  - Defined: packet lock. After a beat with tlast=0 is accepted, the grant stays locked to that channel. Only that channel is eligible until its tlast=1 beat is accepted. The lock also releases if that channel's mask bit is cleared.
  - Undefined: every beat is arbitrated independently and tlast is only forwarded.

## Structure
- Package wfg_drive_spi_arb_pkg holds:
  - the state enum (ST_IDLE=1'b0, ST_HOLD=1'b1);
  - MAX_NUM_CH=8;
  - the beat counter width constant.
- Sub-module wfg_rr_picker, purely combinational:
  - inputs: request vector, last_grant;
  - outputs: one-hot winner and any-valid flag.

## Test plan
- Reset, then ch0 valid with data 0xA5A5_0001 -> s_axis_tready_o=0001 for one cycle; next cycle m_axis_tvalid_o=1, tdata=0xA5A5_0001, ch_sel_o=0001.
- All four channels continuously valid, m_axis_tready_i pulsed after each load -> grant order 0,1,2,3,0; beat_cnt_o=5.
- cfg_mask_q_i=0101 with all valid -> only channels 0,2 are served, alternating; channels 1,3 never see tready.
- ctrl_en_q_i dropped while in ST_HOLD -> the word is still delivered on m_axis_tready_i; no further accepts until re-enabled.
- LOCK_EN defined; ch1 sends 3 beats with tlast on the third while ch2 is also valid -> order 1,1,1,2.
- Counter preloaded to 0xFFFF by 65535 deliveries, one more delivery -> stays 0xFFFF; cnt_clr_i together with a delivery -> 0.
